// File: rtl/branch_compare_seq_pkg.sv
// rv_branch_pkg: shared FSM encoding, default operand width and slice-index width helper
package rv_branch_pkg;
  localparam int XLEN_DEF = 32;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CMP  = 2'b01,
    DONE = 2'b10
  } state_e;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/branch_compare_seq_if.sv
// branch_compare_seq_if: operand request (start_*, rs1, rs2) and flag response (done_*, Br*) handshakes
// master drives operands and done_ready; slave (the comparator) drives start_ready, done_valid and flags
interface branch_compare_seq_if import rv_branch_pkg::*; #(
  parameter int XLEN = XLEN_DEF
);
  logic            start_valid;
  logic            start_ready;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            done_valid;
  logic            done_ready;
  logic            BrEq;
  logic            BrLt;
  logic            BrLtU;
  modport master (
    output start_valid, rs1, rs2, done_ready,
    input  start_ready, done_valid, BrEq, BrLt, BrLtU
  );
  modport slave (
    input  start_valid, rs1, rs2, done_ready,
    output start_ready, done_valid, BrEq, BrLt, BrLtU
  );
endinterface

// File: rtl/branch_compare_seq_slice_cmp.sv
// slice_cmp: combinational compare of one W-bit slice
// ports: a, b (slices), eq (a == b), ltu (a < b unsigned)
module slice_cmp #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq,
  output logic         ltu
);
  assign eq  = a == b;
  assign ltu = a < b;
endmodule

// File: rtl/branch_compare_seq.sv
// branch_compare_seq: iterative MSB-first branch comparator producing BrEq/BrLt/BrLtU
// ports: clk, rst_n (async, active-low), bus (slave side of branch_compare_seq_if)
module branch_compare_seq import rv_branch_pkg::*; #(
  parameter int XLEN  = XLEN_DEF,
  parameter int CHUNK = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  branch_compare_seq_if.slave bus
);
  localparam int NCHUNK = XLEN / CHUNK;
  localparam int KW     = idx_w(NCHUNK);
  if (XLEN % CHUNK != 0) begin : g_bad_chunk
    $error("XLEN (%0d) must be a multiple of CHUNK (%0d)", XLEN, CHUNK);
  end
  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d, sh1, sh2;
  logic            breq_q, breq_d, brlt_q, brlt_d, brltu_q, brltu_d;
  logic            eq, ltu, sign_diff;
  // slice k is moved to the top bits, so the compared slice is always the MSB window
  assign sh1       = rs1_q << (int'(k_q) * CHUNK);
  assign sh2       = rs2_q << (int'(k_q) * CHUNK);
  assign sign_diff = rs1_q[XLEN-1] != rs2_q[XLEN-1];
  slice_cmp #(.W(CHUNK)) u_cmp (
    .a   (sh1[XLEN-1 -: CHUNK]),
    .b   (sh2[XLEN-1 -: CHUNK]),
    .eq  (eq),
    .ltu (ltu)
  );
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    breq_d  = breq_q;
    brlt_d  = brlt_q;
    brltu_d = brltu_q;
    case (state_q)
      IDLE: if (bus.start_valid) begin
        rs1_d   = bus.rs1;
        rs2_d   = bus.rs2;
        k_d     = '0;
        state_d = CMP;
      end
      CMP: if (!eq) begin
        // a sign difference always shows up in slice 0, so it is resolved on the k=0 cycle
        breq_d  = 1'b0;
        brltu_d = ltu;
        brlt_d  = sign_diff ? rs1_q[XLEN-1] : ltu;
        state_d = DONE;
      end else if (k_q == KW'(NCHUNK - 1)) begin
        breq_d  = 1'b1;
        brlt_d  = 1'b0;
        brltu_d = 1'b0;
        state_d = DONE;
      end else begin
        k_d = k_q + 1'b1;
      end
      DONE: state_d = bus.done_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      breq_q  <= 1'b0;
      brlt_q  <= 1'b0;
      brltu_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      breq_q  <= breq_d;
      brlt_q  <= brlt_d;
      brltu_q <= brltu_d;
    end
  end
  assign bus.start_ready = state_q == IDLE;
  assign bus.done_valid  = state_q == DONE;
  assign bus.BrEq        = breq_q;
  assign bus.BrLt        = brlt_q;
  assign bus.BrLtU       = brltu_q;
endmodule

// File: tb/tb_branch_compare_seq.sv
// tb_branch_compare_seq: directed self-checking bench for CHUNK=8 and CHUNK=32 builds
module tb_branch_compare_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        sv = 1'b0;
  logic        done_ready = 1'b0;
  logic [31:0] rs1_v = '0;
  logic [31:0] rs2_v = '0;
  logic [2:0]  prev [2];
  int          n_cmp = 0;
  int          n_bad = 0;
  always #5 clk = ~clk;
  branch_compare_seq_if #(.XLEN(32)) b0 ();
  branch_compare_seq_if #(.XLEN(32)) b1 ();
  assign b0.start_valid = sv & ~sel;
  assign b1.start_valid = sv & sel;
  assign b0.rs1 = rs1_v;
  assign b0.rs2 = rs2_v;
  assign b1.rs1 = rs1_v;
  assign b1.rs2 = rs2_v;
  assign b0.done_ready = done_ready;
  assign b1.done_ready = done_ready;
  branch_compare_seq #(.XLEN(32), .CHUNK(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  branch_compare_seq #(.XLEN(32), .CHUNK(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  wire sr  = sel ? b1.start_ready : b0.start_ready;
  wire dv  = sel ? b1.done_valid  : b0.done_valid;
  wire eq  = sel ? b1.BrEq        : b0.BrEq;
  wire lt  = sel ? b1.BrLt        : b0.BrLt;
  wire ltu = sel ? b1.BrLtU       : b0.BrLtU;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run(input bit s, input logic [31:0] a, input logic [31:0] b, input int lat_exp,
                     input bit e, input bit l, input bit lu, input string tag);
    int lat;
    sel = s;
    done_ready = 1'b1;
    @(negedge clk);
    check({tag, ":ready"}, 32'(sr), 1);
    sv = 1'b1;
    rs1_v = a;
    rs2_v = b;
    @(posedge clk);
    #1 sv = 1'b0;
    check({tag, ":busy"}, 32'(sr), 0);
    check({tag, ":held"}, 32'({eq, lt, ltu}), 32'(prev[s]));
    lat = 0;
    while (!dv && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    check({tag, ":lat"}, 32'(lat), 32'(lat_exp));
    check({tag, ":flags"}, 32'({eq, lt, ltu}), 32'({e, l, lu}));
    prev[s] = {e, l, lu};
    @(posedge clk);
    #1;
    check({tag, ":release"}, 32'({dv, sr}), 32'b01);
  endtask
  initial begin
    prev[0] = 3'b000;
    prev[1] = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    check("rst8", 32'({b0.start_ready, b0.done_valid, b0.BrEq, b0.BrLt, b0.BrLtU}), 32'b10000);
    check("rst32", 32'({b1.start_ready, b1.done_valid, b1.BrEq, b1.BrLt, b1.BrLtU}), 32'b10000);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 32'h12345678, 32'h12345678, 4, 1, 0, 0, "eq");
    run(0, 32'h80000000, 32'h00000001, 1, 0, 1, 0, "sign");
    run(0, 32'h00000005, 32'h00000007, 4, 0, 1, 1, "late");
    run(0, 32'h00000007, 32'h00000005, 4, 0, 0, 0, "late_swap");
    run(0, 32'h12345678, 32'h12355678, 2, 0, 1, 1, "mid");
    run(0, 32'h80000000, 32'hFFFFFFFF, 1, 0, 1, 1, "neg_neg");
    run(0, 32'h00000000, 32'h00000000, 4, 1, 0, 0, "zero");
    // backpressure: hold done_ready low and poke start_valid while DONE is held
    sel = 1'b0;
    @(negedge clk);
    done_ready = 1'b0;
    sv = 1'b1;
    rs1_v = 32'hFFFFFFFF;
    rs2_v = 32'h7FFFFFFF;
    @(posedge clk);
    #1 sv = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("bp:hold", 32'({dv, sr, eq, lt, ltu}), 32'b10010);
      sv = (i == 1);
      rs1_v = 32'h0;
      rs2_v = 32'h0;
      @(posedge clk);
      #1;
    end
    sv = 1'b0;
    check("bp:still", 32'({dv, sr, eq, lt, ltu}), 32'b10010);
    done_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp:done", 32'({dv, sr, eq, lt, ltu}), 32'b01010);
    prev[0] = 3'b010;
    // asynchronous reset two cycles into a compare
    @(negedge clk);
    sv = 1'b1;
    rs1_v = 32'h00000001;
    rs2_v = 32'h00000002;
    @(posedge clk);
    #1 sv = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid", 32'({b0.start_ready, b0.done_valid, b0.BrEq, b0.BrLt, b0.BrLtU}), 32'b10000);
    prev[0] = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 32'h00000000, 32'h00000000, 4, 1, 0, 0, "post_rst");
    run(1, 32'hFFFFFFFE, 32'hFFFFFFFF, 1, 0, 1, 1, "c32_neg");
    run(1, 32'h00000007, 32'h00000007, 1, 1, 0, 0, "c32_eq");
    run(1, 32'h80000000, 32'h00000001, 1, 0, 1, 0, "c32_sign");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
endmodule
